// File: rtl/ad9361_pkg.sv
// Shared types and helpers for the AD9361 transmit-side deserializer.
package ad9361_pkg;

    localparam int unsigned NUM_FIELDS = 8;
    localparam int unsigned NUM_CHAN   = 4;
    localparam int unsigned SAMPLE_W   = 12;
    localparam int unsigned COUNT_W    = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_RUN  = 2'd2
    } tx_state_e;

    typedef struct packed {
        logic [SAMPLE_W-1:0] i;
        logic [SAMPLE_W-1:0] q;
    } iq_sample_t;

    // Output slot encoding: slot[2:1] is the channel, slot[0] selects Q over I.
    localparam logic [2:0] FIELD_SLOT_FWD [NUM_FIELDS] = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
    localparam logic [2:0] FIELD_SLOT_REV [NUM_FIELDS] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};

    function automatic logic [2:0] field_slot(logic [2:0] field, logic reverse);
        return reverse ? FIELD_SLOT_REV[field] : FIELD_SLOT_FWD[field];
    endfunction

    // Left-justify a PRECISION-bit field into the 12-bit DAC word.
    function automatic logic [SAMPLE_W-1:0] unpack_field(logic [SAMPLE_W-1:0] field,
                                                         int unsigned precision);
        return SAMPLE_W'(field << (SAMPLE_W - precision));
    endfunction

endpackage

// File: rtl/ad9361_tx_sample_fifo.sv
// First-word-fall-through sample buffer; rst also serves as the flush input.
module ad9361_tx_sample_fifo #(
    parameter int unsigned WIDTH = 96,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic                     full,
    output logic                     empty
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic             do_push_c, do_pop_c;

    assign full      = (occ_q == OCC_W'(DEPTH));
    assign empty     = (occ_q == '0);
    assign occupancy = occ_q;
    assign rd_data   = mem_q[rd_ptr_q];

    always_comb begin
        do_push_c = push && !full;
        do_pop_c  = pop && !empty;
        wr_ptr_d  = wr_ptr_q + PTR_W'(do_push_c);
        rd_ptr_d  = rd_ptr_q + PTR_W'(do_pop_c);
        occ_d     = occ_q + OCC_W'(do_push_c) - OCC_W'(do_pop_c);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    // Storage is not reset; pointers alone define validity.
    always_ff @(posedge clk) begin
        if (do_push_c) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/ad9361_dual_axis_tx.sv
// AXI-stream to 4-channel AD9361 DAC sample deserializer with prime-before-run buffering.
module ad9361_dual_axis_tx
    import ad9361_pkg::*;
#(
    parameter int unsigned PRECISION         = 12,
    parameter int unsigned REVERSE_DATA      = 0,
    parameter int unsigned USE_AXIS_TLAST    = 0,
    parameter int unsigned AXIS_BURST_LENGTH = 512,
    parameter int unsigned BUFFER_DEPTH      = 8,
    parameter int unsigned UNDERFLOW_HOLD    = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic                     s_axis_tvalid,
    output logic                     s_axis_tready,
    input  logic [8*PRECISION-1:0]   s_axis_tdata,
    input  logic                     s_axis_tlast,
    input  logic                     dac_req,
    output logic                     valid_0,
    output logic                     valid_1,
    output logic                     valid_2,
    output logic                     valid_3,
    output logic [11:0]              data_i0,
    output logic [11:0]              data_i1,
    output logic [11:0]              data_i2,
    output logic [11:0]              data_i3,
    output logic [11:0]              data_q0,
    output logic [11:0]              data_q1,
    output logic [11:0]              data_q2,
    output logic [11:0]              data_q3,
    output logic                     underflow,
    output logic [15:0]              underflow_count,
    output logic                     burst_error
);
    localparam int unsigned DATA_W = NUM_FIELDS * PRECISION;
    localparam int unsigned OCC_W  = $clog2(BUFFER_DEPTH) + 1;
    localparam int unsigned HALF   = BUFFER_DEPTH / 2;
    localparam int unsigned BEAT_W = $clog2(AXIS_BURST_LENGTH);

    tx_state_e                 state_q, state_d;
    iq_sample_t [NUM_CHAN-1:0] chan_q, chan_d, unpacked_c;
    logic                      valid_q, valid_d;
    logic                      underflow_q, underflow_d;
    logic                      burst_error_q, burst_error_d;
    logic                      tready_q, tready_d;
    logic [COUNT_W-1:0]        uf_count_q, uf_count_d;
    logic [BEAT_W-1:0]         beat_q, beat_d;

    logic                      flush_c, push_c, pop_c;
    logic [OCC_W-1:0]          occupancy, occ_next_c;
    logic                      fifo_full, fifo_empty;
    logic [DATA_W-1:0]         fifo_rd_data;
    logic [2:0]                slot_c;
    logic [SAMPLE_W-1:0]       sample_c;

    ad9361_tx_sample_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (BUFFER_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst || flush_c),
        .push      (push_c),
        .wr_data   (s_axis_tdata),
        .pop       (pop_c),
        .rd_data   (fifo_rd_data),
        .occupancy (occupancy),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Scatter the head-of-buffer word into per-channel I/Q samples.
    always_comb begin
        unpacked_c = '0;
        slot_c     = '0;
        sample_c   = '0;
        for (int unsigned n = 0; n < NUM_FIELDS; n++) begin
            slot_c   = field_slot(3'(n), REVERSE_DATA != 0);
            sample_c = unpack_field(SAMPLE_W'(fifo_rd_data[n*PRECISION +: PRECISION]), PRECISION);
            if (slot_c[0]) begin
                unpacked_c[slot_c[2:1]].q = sample_c;
            end else begin
                unpacked_c[slot_c[2:1]].i = sample_c;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        chan_d        = chan_q;
        valid_d       = 1'b0;
        underflow_d   = 1'b0;
        burst_error_d = 1'b0;
        uf_count_d    = uf_count_q;
        beat_d        = beat_q;
        pop_c         = 1'b0;
        flush_c       = !enable || (state_q == ST_IDLE);
        push_c        = s_axis_tvalid && tready_q && !flush_c;

        if (!enable) begin
            state_d = ST_IDLE;
            chan_d  = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d = ST_FILL;
                    chan_d  = '0;
                end
                ST_FILL: begin
                    // Priming: requests are answered silently without consuming data.
                    if (dac_req) begin
                        valid_d = 1'b1;
                        if (UNDERFLOW_HOLD == 0) begin
                            chan_d = '0;
                        end
                    end
                    if (occupancy >= OCC_W'(HALF)) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (dac_req) begin
                        valid_d = 1'b1;
                        if (!fifo_empty) begin
                            pop_c  = 1'b1;
                            chan_d = unpacked_c;
                        end else begin
                            underflow_d = 1'b1;
                            if (uf_count_q != '1) begin
                                uf_count_d = uf_count_q + COUNT_W'(1);
                            end
                            if (UNDERFLOW_HOLD == 0) begin
                                chan_d = '0;
                            end
                            state_d = ST_FILL;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // Framing check only reports; accepted data is always kept.
        if ((USE_AXIS_TLAST != 0) && push_c) begin
            if (beat_q == BEAT_W'(AXIS_BURST_LENGTH - 1)) begin
                burst_error_d = !s_axis_tlast;
                beat_d        = '0;
            end else if (s_axis_tlast) begin
                burst_error_d = 1'b1;
                beat_d        = '0;
            end else begin
                beat_d = beat_q + BEAT_W'(1);
            end
        end
        if (flush_c) begin
            beat_d = '0;
        end

        occ_next_c = flush_c ? '0 : (occupancy + OCC_W'(push_c) - OCC_W'(pop_c));
        tready_d   = (state_d != ST_IDLE) && (occ_next_c != OCC_W'(BUFFER_DEPTH));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            chan_q        <= '0;
            valid_q       <= 1'b0;
            underflow_q   <= 1'b0;
            burst_error_q <= 1'b0;
            tready_q      <= 1'b0;
            uf_count_q    <= '0;
            beat_q        <= '0;
        end else begin
            state_q       <= state_d;
            chan_q        <= chan_d;
            valid_q       <= valid_d;
            underflow_q   <= underflow_d;
            burst_error_q <= burst_error_d;
            tready_q      <= tready_d;
            uf_count_q    <= uf_count_d;
            beat_q        <= beat_d;
        end
    end

    assign s_axis_tready   = tready_q;
    assign valid_0         = valid_q;
    assign valid_1         = valid_q;
    assign valid_2         = valid_q;
    assign valid_3         = valid_q;
    assign data_i0         = chan_q[0].i;
    assign data_q0         = chan_q[0].q;
    assign data_i1         = chan_q[1].i;
    assign data_q1         = chan_q[1].q;
    assign data_i2         = chan_q[2].i;
    assign data_q2         = chan_q[2].q;
    assign data_i3         = chan_q[3].i;
    assign data_q3         = chan_q[3].q;
    assign underflow       = underflow_q;
    assign underflow_count = uf_count_q;
    assign burst_error     = burst_error_q;

endmodule

// File: doc/ad9361_dual_axis_tx.md
# ad9361_dual_axis_tx

Deserializes an AXI-stream of packed 4-channel I/Q words into per-channel 12-bit AD9361 transmit samples. It is paced by a per-sample request strobe from the AD9361 transmit interface. The block sits between the DMA/DSP stream sources and the AD9361 DAC data path, and is the transmit-side counterpart of the receive serializer. It contains a small prime-before-run sample buffer and reports underflow and burst-framing errors.

## Interface
- PRECISION, 12: bits per I or Q field in tdata; 1..12.
- REVERSE_DATA, 0: if 1, field order in tdata is reversed.
- USE_AXIS_TLAST, 0: if 1, s_axis_tlast is checked against AXIS_BURST_LENGTH.
- AXIS_BURST_LENGTH, 512: beats per burst when tlast is checked; ≥2.
- BUFFER_DEPTH, 8: sample buffer entries; power of 2, ≥4.
- UNDERFLOW_HOLD, 0: on underflow, 0 outputs zeros and 1 repeats the last sample.

Ports:
- clk  in  1  single clock. Reset is synchronous and active-high.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  streaming enable; level-sensitive.
- s_axis_tvalid  in  1  AXI-stream valid.
- s_axis_tready  out  1  AXI-stream ready.
- s_axis_tdata  in  8*PRECISION  packed samples.
- s_axis_tlast  in  1  burst end; ignored unless USE_AXIS_TLAST.
- dac_req  in  1  one-cycle strobe, one per DAC sample period.
- valid_0..valid_3  out  1 each  per-channel sample strobe.
- data_i0..data_i3, data_q0..data_q3  out  12 each  DAC samples.
- underflow  out  1  one-cycle pulse for each request served with no data.
- underflow_count  out  16  saturating underflow count; cleared by rst only.
- burst_error  out  1  one-cycle pulse on a tlast framing mismatch.

## Operation
- Field mapping: field n occupies tdata[n*P+P-1 : n*P].
  - Without REVERSE_DATA, fields 0..7 map to q3, i3, q2, i2, q1, i1, q0, i0.
  - With REVERSE_DATA, field n maps to the channel that field 7-n maps to without reversal.
- Width rule: output = {field, (12-PRECISION) zeros}. The field MSB stays the sign bit, with no sign extension beyond the field.
- State machine IDLE/FILL/RUN; rst → IDLE.
  - IDLE: buffer flushed, tready=0, dac_req ignored, outputs held at zero. enable=1 → FILL.
  - FILL: tready = !full. Requests arriving in FILL are served as underflow, but do not count and do not pulse `underflow`. When occupancy ≥ BUFFER_DEPTH/2 → RUN.
  - RUN: tready = !full. On dac_req, pop one entry and drive all 8 outputs with all four valid_n. If the buffer is empty on dac_req, apply the UNDERFLOW_HOLD behaviour, still assert all valid_n, pulse underflow, increment underflow_count (saturating at 0xFFFF), and go to FILL.
  - enable=0 in any state → IDLE next cycle. The buffer is flushed and any partial burst count is discarded.
- Buffer:
  - Push when tvalid & tready; pop on served dac_req.
  - tready derives from registered occupancy. When full, no push is accepted even if a pop happens the same cycle.
  - Push and pop in the same cycle leave occupancy unchanged.
- tlast check (USE_AXIS_TLAST=1):
  - Count accepted beats 0..AXIS_BURST_LENGTH-1.
  - tlast on a beat ≠ AXIS_BURST_LENGTH-1: burst_error pulse, count → 0.
  - No tlast on beat AXIS_BURST_LENGTH-1: burst_error pulse, count → 0.
  - Correct tlast: count → 0 with no error.
  - Data is never dropped because of framing errors.

## Timing
- Reset values:
  - tready, all valid_n, all data outputs, underflow, burst_error: 0.
  - underflow_count: 0.
  - state: IDLE.
- Request latency: dac_req in cycle N → data and valid_n registered in cycle N+1. valid_n is high for exactly one cycle.
- Back-to-back dac_req on consecutive cycles is legal; each is served in turn.
- Fill latency: a beat accepted in cycle N is poppable from cycle N+1.
- dac_req and enable falling in the same cycle: the request is ignored.
- burst_error asserts the cycle after the offending beat is accepted.
- underflow asserts in the same cycle as its valid_n.

## Structure
- Package ad9361_pkg holds:
  - the field-to-channel index map for both REVERSE_DATA settings;
  - the state encoding (IDLE=0, FILL=1, RUN=2);
  - an unpack function (field, PRECISION) → 12-bit sample.
- Sub-module ad9361_tx_sample_fifo:
  - synchronous FIFO of width 8*PRECISION and depth BUFFER_DEPTH;
  - provides occupancy, full and empty;
  - takes rst as its flush input.
- The top level holds the FSM, tlast checker, unpack logic and output registers.

## Test plan
- Basic pass-through, PRECISION=12: push 4 words with fields 0..7 = 0x001..0x008. After priming, 4 dac_req → q3=0x001, i3=0x002, …, i0=0x008 on the first strobe, each at N+1.
- PRECISION=8, REVERSE_DATA=1: field 0 = 0x80 → i0 = 0x800; field 7 = 0x7F → q3 = 0x7F0.
- Underflow: BUFFER_DEPTH=8, push 4 words, issue 6 dac_req in RUN.
  - UNDERFLOW_HOLD=0: 5th and 6th requests output zeros, with underflow pulsed once (state moves to FILL), underflow_count=1.
  - UNDERFLOW_HOLD=1: the 4th sample is repeated.
- Full/backpressure: hold dac_req low and keep tvalid high. tready drops after exactly 8 accepts; a simultaneous pop while full still leaves the push unaccepted that cycle.
- tlast, AXIS_BURST_LENGTH=4:
  - tlast on beat 2 → burst_error; the next 4 beats with tlast on the 4th → no error.
  - A missing tlast on beat 3 → burst_error.
- Mid-stream disable and reset: enable 1→0 with 5 entries buffered → IDLE, occupancy 0, outputs 0. rst with underflow_count=3 → count 0 and all outputs 0 next cycle.
